// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between IF, DM and DBG, issuing one registered
// command at a time. Define TOHOST_DETECT_EN to add the sticky prog_done snoop on TOHOST_ADDR.
module mem_port_arbiter #(
  parameter int                ADDR_W      = 32,
  parameter int                MEM_LAT     = 1,
  parameter int                STARVE_MAX  = 4,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h00005000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_wstrb,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [3:0]        dbg_wstrb,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
`ifdef TOHOST_DETECT_EN
  output logic              prog_done,
`endif
  output logic              busy
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
  typedef enum logic [1:0] {SRC_IF, SRC_DM, SRC_DBG} src_t;

  state_t             state, next_state;
  src_t               win, pick;
  logic               pick_valid, pick_we, cmd_we;
  logic [3:0]         pick_wstrb, cmd_wstrb;
  logic [ADDR_W-1:0]  pick_addr, cmd_addr;
  logic [31:0]        pick_wdata, cmd_wdata;
  logic [LAT_W-1:0]   lat_cnt;
  logic [STV_W-1:0]   starve_cnt;
  logic               starve_full, lat_done, wr_done, rd_done;
  logic [31:0]        if_rdata_q, dm_rdata_q, dbg_rdata_q;

  assign starve_full = (starve_cnt == STV_W'(STARVE_MAX));
  assign lat_done    = (lat_cnt == LAT_W'(MEM_LAT));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Arbitration: DBG, then a starved IF, then DM, then IF. Reads never carry byte enables.
  always_comb begin
    next_state = state;
    pick_valid = 1'b0;
    pick       = SRC_IF;
    pick_we    = 1'b0;
    pick_wstrb = '0;
    pick_addr  = if_addr;
    pick_wdata = '0;
    if (dbg_req) begin
      pick_valid = 1'b1;
      pick       = SRC_DBG;
      pick_we    = dbg_we;
      pick_wstrb = dbg_we ? dbg_wstrb : 4'b0000;
      pick_addr  = dbg_addr;
      pick_wdata = dbg_wdata;
    end else if (if_req && starve_full) begin
      pick_valid = 1'b1;
      pick       = SRC_IF;
    end else if (dm_req) begin
      pick_valid = 1'b1;
      pick       = SRC_DM;
      pick_we    = dm_we;
      pick_wstrb = dm_we ? dm_wstrb : 4'b0000;
      pick_addr  = dm_addr;
      pick_wdata = dm_wdata;
    end else if (if_req) begin
      pick_valid = 1'b1;
      pick       = SRC_IF;
    end

    unique case (state)
      IDLE:    if (pick_valid) next_state = CMD;
      CMD:     next_state = cmd_we ? IDLE : WAIT;
      WAIT:    if (lat_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win         <= SRC_IF;
      cmd_we      <= 1'b0;
      cmd_wstrb   <= '0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      lat_cnt     <= '0;
      starve_cnt  <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (state == IDLE) begin
        if (pick_valid) begin
          win       <= pick;
          cmd_we    <= pick_we;
          cmd_wstrb <= pick_wstrb;
          cmd_addr  <= pick_addr;
          cmd_wdata <= pick_wdata;
        end
        if (if_req) begin
          if (pick_valid && pick == SRC_IF) starve_cnt <= '0;
          else if (!starve_full)            starve_cnt <= starve_cnt + STV_W'(1);
        end
      end

      if (state == CMD)
        lat_cnt <= LAT_W'(1);
      else if (state == WAIT && !lat_done)
        lat_cnt <= lat_cnt + LAT_W'(1);

      if (rd_done && win == SRC_IF)  if_rdata_q  <= mem_rdata;
      if (rd_done && win == SRC_DM)  dm_rdata_q  <= mem_rdata;
      if (rd_done && win == SRC_DBG) dbg_rdata_q <= mem_rdata;
    end
  end

  // Acks are gated by rst_n so a read caught by reset in WAIT never completes.
  assign wr_done = rst_n && (state == CMD) && cmd_we;
  assign rd_done = rst_n && (state == WAIT) && lat_done;

  assign if_ack  = (wr_done || rd_done) && (win == SRC_IF);
  assign dm_ack  = (wr_done || rd_done) && (win == SRC_DM);
  assign dbg_ack = (wr_done || rd_done) && (win == SRC_DBG);

  assign if_rdata  = (rd_done && win == SRC_IF)  ? mem_rdata : if_rdata_q;
  assign dm_rdata  = (rd_done && win == SRC_DM)  ? mem_rdata : dm_rdata_q;
  assign dbg_rdata = (rd_done && win == SRC_DBG) ? mem_rdata : dbg_rdata_q;

  assign mem_en    = rst_n && (state == CMD);
  assign mem_wstrb = cmd_wstrb;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign busy      = rst_n && (state != IDLE);

`ifdef TOHOST_DETECT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      prog_done <= 1'b0;
    else if (state == CMD && cmd_we && win != SRC_IF && cmd_wstrb[0] &&
             cmd_addr == TOHOST_ADDR && cmd_wdata[7:0] == 8'h01)
      prog_done <= 1'b1;
  end
`endif

endmodule
